inc_chain_pipe: RTL



---
 rtl/inc_chain_pipe.sv | 100 ++++++++++
 1 files changed

// File: rtl/inc_chain_pipe.sv
// inc_chain_pipe: three-stage registered x -> x+STEP -> x+2*STEP chain.
// Each stage advances when it is empty or its successor is advancing.
// Bubbles therefore collapse, and in_ready only drops when all three stages
// are full and the output is stalled.
module inc_chain_pipe #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z,
  output logic             busy,
  output logic [CNTW-1:0]  count
);
  localparam int STAGES = 3;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
  } trip_t;

  logic [STAGES:1] vld_pipe;
  logic [STAGES:1] adv;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s2_x, s2_y;
  trip_t s3;

  // Advance chain, resolved from the output end back to the input.
  always_comb begin
    adv[3] = !vld_pipe[3] || out_ready;
    adv[2] = !vld_pipe[2] || adv[3];
    adv[1] = !vld_pipe[1] || adv[2];
  end

  assign in_ready  = adv[1];
  assign out_valid = vld_pipe[3];
  assign out_x     = s3.x;
  assign out_y     = s3.y;
  assign out_z     = s3.z;
  assign busy      = |vld_pipe;

  // S1: capture x; an advance with no input leaves a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe[1] <= 1'b0;
      s1_x        <= '0;
    end else if (adv[1]) begin
      vld_pipe[1] <= in_valid;
      if (in_valid) s1_x <= in_x;
    end
  end

  // S2: carry x and form y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe[2] <= 1'b0;
      s2_x        <= '0;
      s2_y        <= '0;
    end else if (adv[2]) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        s2_x <= s1_x;
        s2_y <= s1_x + STEP_W;
      end
    end
  end

  // S3: carry x, y and form z; holds stable while the output is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe[3] <= 1'b0;
      s3          <= '0;
    end else if (adv[3]) begin
      vld_pipe[3] <= vld_pipe[2];
      if (vld_pipe[2]) begin
        s3.x <= s2_x;
        s3.y <= s2_y;
        s3.z <= s2_y + STEP_W;
      end
    end
  end

  // Saturating count of completed output transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (vld_pipe[3] && out_ready && (count != {CNTW{1'b1}}))
      count <= count + CNTW'(1);
  end
endmodule
